// File: rtl/fpu_noncomp.sv
// Pipelined non-computational FP unit: sign injection, min/max, compare, classify.
// Define FPU_NC_CLASS_EN to build the classify op (op 3); otherwise op 3 returns canonical qNaN with NV.
module fpu_noncomp #(
    parameter int EXP_BITS    = 11,
    parameter int MAN_BITS    = 52,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_BITS    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     op,
    input  logic [2:0]                     sub_op,
    input  logic [EXP_BITS+MAN_BITS:0]     opa,
    input  logic [EXP_BITS+MAN_BITS:0]     opb,
    input  logic [TAG_BITS-1:0]            tag_in,
    input  logic                           flush,
    input  logic                           clr_flags,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_BITS+MAN_BITS:0]     result,
    output logic [TAG_BITS-1:0]            tag_out,
    output logic                           invalid,
    output logic                           nv_sticky,
    output logic                           busy
);
    localparam int W = 1 + EXP_BITS + MAN_BITS;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

    logic                sa, sb;
    logic [EXP_BITS-1:0] ea, eb;
    logic [MAN_BITS-1:0] ma, mb;
    logic nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;
    logic any_nan, any_snan, both_zero, mag_lt, mag_gt, lt_total, cmp_lt, cmp_eq;

    assign {sa, ea, ma} = opa;
    assign {sb, eb, mb} = opb;
    assign nan_a     = (&ea) && (|ma);
    assign nan_b     = (&eb) && (|mb);
    assign snan_a    = nan_a && !ma[MAN_BITS-1];
    assign snan_b    = nan_b && !mb[MAN_BITS-1];
    assign zero_a    = ~|opa[W-2:0];
    assign zero_b    = ~|opb[W-2:0];
    assign any_nan   = nan_a || nan_b;
    assign any_snan  = snan_a || snan_b;
    assign both_zero = zero_a && zero_b;
    assign mag_lt    = opa[W-2:0] < opb[W-2:0];
    assign mag_gt    = opa[W-2:0] > opb[W-2:0];
    // Sign-magnitude total order on non-NaN values; -0 sorts below +0 for min/max.
    assign lt_total  = (sa != sb) ? sa : (sa ? mag_gt : mag_lt);
    assign cmp_lt    = lt_total && !both_zero;
    assign cmp_eq    = (opa == opb) || both_zero;

`ifdef FPU_NC_CLASS_EN
    logic       exp_zero_a, exp_max_a, man_zero_a, inf_a, norm_a, sub_a;
    logic [9:0] cls_a;
    assign exp_zero_a = ~|ea;
    assign exp_max_a  = &ea;
    assign man_zero_a = ~|ma;
    assign inf_a      = exp_max_a && man_zero_a;
    assign norm_a     = !exp_zero_a && !exp_max_a;
    assign sub_a      = exp_zero_a && !man_zero_a;
    assign cls_a = {nan_a && ma[MAN_BITS-1], snan_a,
                    !sa && inf_a, !sa && norm_a, !sa && sub_a, !sa && zero_a,
                    sa && zero_a, sa && sub_a, sa && norm_a, sa && inf_a};
`endif

    logic [W-1:0] res_c;
    logic         nv_c;

    always_comb begin
        res_c = QNAN;
        nv_c  = 1'b1;
        case (op)
            2'd0: if (sub_op <= 3'd2) begin
                nv_c = 1'b0;
                case (sub_op)
                    3'd0:    res_c = {sb, opa[W-2:0]};
                    3'd1:    res_c = {~sb, opa[W-2:0]};
                    default: res_c = {sa ^ sb, opa[W-2:0]};
                endcase
            end
            2'd1: if (sub_op <= 3'd1) begin
                nv_c = any_snan;
                if (nan_a && nan_b)      res_c = QNAN;
                else if (nan_a)          res_c = opb;
                else if (nan_b)          res_c = opa;
                else if (sub_op == 3'd0) res_c = lt_total ? opa : opb;
                else                     res_c = lt_total ? opb : opa;
            end
            2'd2: if (sub_op <= 3'd2) begin
                res_c = '0;
                nv_c  = (sub_op == 3'd2) ? any_snan : any_nan;
                if (!any_nan) begin
                    case (sub_op)
                        3'd0:    res_c[0] = cmp_lt || cmp_eq;
                        3'd1:    res_c[0] = cmp_lt;
                        default: res_c[0] = cmp_eq;
                    endcase
                end
            end
            default: begin
`ifdef FPU_NC_CLASS_EN
                res_c = {{(W-10){1'b0}}, cls_a};
                nv_c  = 1'b0;
`endif
            end
        endcase
    end

    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] nv_q;
    logic [W-1:0]           res_q [PIPE_STAGES];
    logic [TAG_BITS-1:0]    tag_q [PIPE_STAGES];
    logic                   en;

    // One global enable: a stalled output freezes every stage, bubbles included.
    assign out_valid = vld_q[PIPE_STAGES-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en && !flush;
    assign busy      = |vld_q;
    assign result    = res_q[PIPE_STAGES-1];
    assign tag_out   = tag_q[PIPE_STAGES-1];
    assign invalid   = nv_q[PIPE_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            nv_q  <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                res_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (en) begin
                vld_q[0] <= in_valid && in_ready;
                for (int i = 1; i < PIPE_STAGES; i++) vld_q[i] <= vld_q[i-1];
            end
            if (en) begin
                res_q[0] <= res_c;
                tag_q[0] <= tag_in;
                nv_q[0]  <= nv_c;
                for (int i = 1; i < PIPE_STAGES; i++) begin
                    res_q[i] <= res_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                    nv_q[i]  <= nv_q[i-1];
                end
            end
        end
    end

    // A flushed output slot is not a handshake, so it never sets the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nv_sticky <= 1'b0;
        else if (out_valid && out_ready && !flush && invalid)
            nv_sticky <= 1'b1;
        else if (clr_flags)
            nv_sticky <= 1'b0;
    end
endmodule
